// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared types and header constants for the TX frame builder
//
// Purpose : FSM state type and fixed Ethernet/IPv4/UDP header field values.
// Ports   : none (package).
package tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_HDR,
    ST_PAYLOAD,
    ST_DRAIN
  } tx_state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
  localparam logic [7:0]  IP_TTL         = 8'd64;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam int          HDR_WORDS      = 11;

endpackage

// File: rtl/ipv4_hdr_csum.sv
// rtl/ipv4_hdr_csum.sv - one's-complement sum of a 10-halfword IPv4 header
//
// Purpose : combinational sum of the ten header halfwords with end-around
//           carry fold. The caller complements the result to generate a
//           checksum; a result of 16'hFFFF over a received header (checksum
//           field included) means the header is intact.
// Ports   : hdr_hw   in  10 x 16  header halfwords, any order
//           sum_fold out 16       folded one's-complement sum (not inverted)
module ipv4_hdr_csum (
  input  logic [9:0][15:0] hdr_hw,
  output logic [15:0]      sum_fold
);

  logic [19:0] acc;
  logic [16:0] fold1;

  // Ten 16-bit terms fit in 20 bits. Two folds are enough: after the first
  // fold a carry out of bit 15 implies the low half is small, so adding it
  // back in cannot carry again.
  always_comb begin
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      acc = acc + {4'b0, hdr_hw[i]};
    end
    fold1    = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
    sum_fold = fold1[15:0] + {15'b0, fold1[16]};
  end

endmodule

// File: rtl/tx_frame_builder.sv
// rtl/tx_frame_builder.sv - Ethernet/IPv4/UDP transmit frame builder
//
// Purpose : accepts a TX request, emits an 11-word header (2-byte zero pad,
//           Ethernet, IPv4 with checksum, UDP) then passes the payload
//           through from the PBM read port.
// Ports   : clk, rst_n                      clock, async active-low reset
//           i_meta_valid/o_meta_ready       request handshake
//           i_meta_len/_dst_mac/_dst_ip/_dst_port  request fields
//           cfg_src_mac/_src_ip/_src_port   local identity, sampled on accept
//           i_pbm_rdata/_rvalid/_rlast, o_pbm_rready  PBM read port
//           m_axis_tdata/_tvalid/_tlast/_tuser, m_axis_tready  frame out
//           tx_pkt_cnt/tx_reject_cnt/tx_err_cnt  statistics
module tx_frame_builder
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PAYLOAD = 1472
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_meta_valid,
  output logic                  o_meta_ready,
  input  logic [15:0]           i_meta_len,
  input  logic [47:0]           i_meta_dst_mac,
  input  logic [31:0]           i_meta_dst_ip,
  input  logic [15:0]           i_meta_dst_port,
  input  logic [47:0]           cfg_src_mac,
  input  logic [31:0]           cfg_src_ip,
  input  logic [15:0]           cfg_src_port,
  input  logic [DATA_WIDTH-1:0] i_pbm_rdata,
  input  logic                  i_pbm_rvalid,
  input  logic                  i_pbm_rlast,
  output logic                  o_pbm_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [31:0]           tx_pkt_cnt,
  output logic [31:0]           tx_reject_cnt,
  output logic [31:0]           tx_err_cnt
);

  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
  localparam logic [3:0]  HDR_LAST = 4'(HDR_WORDS - 1);

  tx_state_t       state;
  logic [3:0]      hdr_idx;
  logic [15:0]     len_q;
  logic [47:0]     dst_mac_q;
  logic [31:0]     dst_ip_q;
  logic [15:0]     dst_port_q;
  logic [47:0]     src_mac_q;
  logic [31:0]     src_ip_q;
  logic [15:0]     src_port_q;
  logic [15:0]     ip_csum;
  logic [15:0]     ip_id;
  logic [15:0]     words_left;

  logic [15:0]           ip_total_len;
  logic [15:0]           udp_len;
  logic [9:0][15:0]      csum_hw;
  logic [15:0]           csum_fold;
  logic [DATA_WIDTH-1:0] hdr_word;
  logic                  meta_legal;
  logic                  at_last_word;
  logic                  payload_last;
  logic                  payload_err;
  logic                  payload_hs;

  // Lengths are bounded by MAX_PAYLOAD, so 16-bit sums cannot overflow.
  assign ip_total_len = len_q + 16'd28;
  assign udp_len      = len_q + 16'd8;

  assign meta_legal = (i_meta_len != 16'd0) && (i_meta_len[3:0] == 4'd0) &&
                      (i_meta_len <= MAX_LEN);

  // Checksum field itself is zero while the checksum is computed.
  assign csum_hw = {IP_VER_IHL_TOS, ip_total_len, ip_id, IP_FLAGS_DF,
                    {IP_TTL, IP_PROTO_UDP}, 16'h0000,
                    src_ip_q[31:16], src_ip_q[15:0],
                    dst_ip_q[31:16], dst_ip_q[15:0]};

  ipv4_hdr_csum u_csum (
    .hdr_hw   (csum_hw),
    .sum_fold (csum_fold)
  );

  // Header words come only from registers latched at accept, so the word
  // stays stable for as long as the MAC stalls.
  always_comb begin
    hdr_word = '0;
    case (hdr_idx)
      4'd0:    hdr_word = {16'h0000, dst_mac_q[47:32]};
      4'd1:    hdr_word = dst_mac_q[31:0];
      4'd2:    hdr_word = src_mac_q[47:16];
      4'd3:    hdr_word = {src_mac_q[15:0], ETHERTYPE_IPV4};
      4'd4:    hdr_word = {IP_VER_IHL_TOS, ip_total_len};
      4'd5:    hdr_word = {ip_id, IP_FLAGS_DF};
      4'd6:    hdr_word = {IP_TTL, IP_PROTO_UDP, ip_csum};
      4'd7:    hdr_word = src_ip_q;
      4'd8:    hdr_word = dst_ip_q;
      4'd9:    hdr_word = {src_port_q, dst_port_q};
      4'd10:   hdr_word = {udp_len, 16'h0000};
      default: hdr_word = '0;
    endcase
  end

  // End of payload is either the expected last word or the buffer's last
  // word; a disagreement between the two marks the frame as errored.
  assign at_last_word = (words_left == 16'd1);
  assign payload_last = i_pbm_rlast || at_last_word;
  assign payload_err  = i_pbm_rlast != at_last_word;
  assign payload_hs   = i_pbm_rvalid && m_axis_tready;

  always_comb begin
    o_meta_ready  = (state == ST_IDLE);
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    o_pbm_rready  = 1'b0;
    case (state)
      ST_HDR: begin
        m_axis_tdata  = hdr_word;
        m_axis_tvalid = 1'b1;
      end
      ST_PAYLOAD: begin
        m_axis_tdata  = i_pbm_rdata;
        m_axis_tvalid = i_pbm_rvalid;
        m_axis_tlast  = i_pbm_rvalid && payload_last;
        m_axis_tuser  = i_pbm_rvalid && payload_last && payload_err;
        o_pbm_rready  = m_axis_tready;
      end
      ST_DRAIN: o_pbm_rready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      hdr_idx       <= '0;
      len_q         <= '0;
      dst_mac_q     <= '0;
      dst_ip_q      <= '0;
      dst_port_q    <= '0;
      src_mac_q     <= '0;
      src_ip_q      <= '0;
      src_port_q    <= '0;
      ip_csum       <= '0;
      ip_id         <= '0;
      words_left    <= '0;
      tx_pkt_cnt    <= '0;
      tx_reject_cnt <= '0;
      tx_err_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_meta_valid) begin
            len_q      <= i_meta_len;
            dst_mac_q  <= i_meta_dst_mac;
            dst_ip_q   <= i_meta_dst_ip;
            dst_port_q <= i_meta_dst_port;
            src_mac_q  <= cfg_src_mac;
            src_ip_q   <= cfg_src_ip;
            src_port_q <= cfg_src_port;
            if (meta_legal) begin
              state <= ST_CSUM;
            end else begin
              tx_reject_cnt <= tx_reject_cnt + 32'd1;
              state         <= ST_DRAIN;
            end
          end
        end
        ST_CSUM: begin
          ip_csum    <= ~csum_fold;
          hdr_idx    <= '0;
          words_left <= {2'b00, len_q[15:2]};
          state      <= ST_HDR;
        end
        ST_HDR: begin
          if (m_axis_tready) begin
            if (hdr_idx == HDR_LAST) begin
              state <= ST_PAYLOAD;
            end else begin
              hdr_idx <= hdr_idx + 4'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (payload_hs) begin
            words_left <= words_left - 16'd1;
            if (payload_last) begin
              ip_id <= ip_id + 16'd1;
              if (payload_err) begin
                tx_err_cnt <= tx_err_cnt + 32'd1;
              end else begin
                tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
              end
              // A buffer longer than the request still holds words to drop.
              state <= (at_last_word && !i_pbm_rlast) ? ST_DRAIN : ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (i_pbm_rvalid && i_pbm_rlast) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_builder.sv
// tb/tb_tx_frame_builder.sv - scoreboard bench for tx_frame_builder
module tb_tx_frame_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_meta_valid = 1'b0;
  logic        o_meta_ready;
  logic [15:0] i_meta_len = '0;
  logic [47:0] i_meta_dst_mac = 48'h02_00_00_00_00_02;
  logic [31:0] i_meta_dst_ip = 32'hC0A80114;
  logic [15:0] i_meta_dst_port = 16'h5678;
  logic [47:0] cfg_src_mac = 48'h02_00_00_00_00_01;
  logic [31:0] cfg_src_ip = 32'hC0A8010A;
  logic [15:0] cfg_src_port = 16'h1234;
  logic [31:0] i_pbm_rdata = '0;
  logic        i_pbm_rvalid = 1'b0;
  logic        i_pbm_rlast = 1'b0;
  logic        o_pbm_rready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tready = 1'b1;
  logic [31:0] tx_pkt_cnt;
  logic [31:0] tx_reject_cnt;
  logic [31:0] tx_err_cnt;

  tx_frame_builder #(.DATA_WIDTH(32), .MAX_PAYLOAD(1472)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_meta_valid    (i_meta_valid),
    .o_meta_ready    (o_meta_ready),
    .i_meta_len      (i_meta_len),
    .i_meta_dst_mac  (i_meta_dst_mac),
    .i_meta_dst_ip   (i_meta_dst_ip),
    .i_meta_dst_port (i_meta_dst_port),
    .cfg_src_mac     (cfg_src_mac),
    .cfg_src_ip      (cfg_src_ip),
    .cfg_src_port    (cfg_src_port),
    .i_pbm_rdata     (i_pbm_rdata),
    .i_pbm_rvalid    (i_pbm_rvalid),
    .i_pbm_rlast     (i_pbm_rlast),
    .o_pbm_rready    (o_pbm_rready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tready   (m_axis_tready),
    .tx_pkt_cnt      (tx_pkt_cnt),
    .tx_reject_cnt   (tx_reject_cnt),
    .tx_err_cnt      (tx_err_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];   // {tdata, tlast, tuser}
  logic [32:0] pbm_q[$];   // {rlast, rdata}
  int          frame_idx = 0;
  logic [15:0] exp_ip_id = 16'h0000;
  logic        bp_mode = 1'b0;
  int          stall_cnt = 0;

  // Basic frame header, worked out by hand for ip_id=0 and len=64.
  logic [31:0] basic_hdr [11] = '{
    32'h00000200, 32'h00000002, 32'h02000000, 32'h00010800,
    32'h4500005C, 32'h00004000, 32'h4011B722, 32'hC0A8010A,
    32'hC0A80114, 32'h12345678, 32'h00480000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_csum(input logic [15:0] len, input logic [15:0] id);
    logic [31:0] s;
    s = 32'h4500 + 32'h4000 + 32'h4011 + 32'(len) + 32'd28 + 32'(id) +
        32'(cfg_src_ip[31:16]) + 32'(cfg_src_ip[15:0]) +
        32'(i_meta_dst_ip[31:16]) + 32'(i_meta_dst_ip[15:0]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic logic [31:0] model_hdr(input int i, input logic [15:0] len, input logic [15:0] id);
    case (i)
      0:  return {16'h0000, i_meta_dst_mac[47:32]};
      1:  return i_meta_dst_mac[31:0];
      2:  return cfg_src_mac[47:16];
      3:  return {cfg_src_mac[15:0], 16'h0800};
      4:  return {16'h4500, len + 16'd28};
      5:  return {id, 16'h4000};
      6:  return {8'd64, 8'd17, model_csum(len, id)};
      7:  return cfg_src_ip;
      8:  return i_meta_dst_ip;
      9:  return {cfg_src_port, i_meta_dst_port};
      default: return {len + 16'd8, 16'h0000};
    endcase
  endfunction

  // Expected frame for a legal request against a PBM buffer of nbuf words.
  task automatic push_frame(input logic [15:0] len, input int nbuf, input logic [31:0] base, input bit literal);
    int wl;
    logic lb, tl, tu;
    for (int i = 0; i < 11; i++)
      exp_q.push_back({literal ? basic_hdr[i] : model_hdr(i, len, exp_ip_id), 2'b00});
    wl = int'(len) / 4;
    for (int k = 0; k < nbuf; k++) begin
      lb = (k == nbuf - 1);
      tl = lb || (wl - k == 1);
      tu = tl && (lb != (wl - k == 1));
      exp_q.push_back({base + 32'(k), tl, tu});
      if (tl) break;
    end
    exp_ip_id = exp_ip_id + 16'd1;
  endtask

  task automatic load_pbm(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) pbm_q.push_back({k == n - 1, base + 32'(k)});
  endtask

  task automatic send_meta(input logic [15:0] len);
    int n = 0;
    bit done = 0;
    @(posedge clk); #1;
    i_meta_len   = len;
    i_meta_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (o_meta_ready) done = 1;
      else if (++n > 500) begin
        check("meta_timeout", 64'(o_meta_ready), 64'd1);
        done = 1;
      end
    end
    @(posedge clk); #1;
    i_meta_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() == 0 && pbm_q.size() == 0 && o_meta_ready) done = 1;
      else if (++n > 2000) begin
        check("idle_timeout", 64'(exp_q.size() + pbm_q.size()), 64'd0);
        exp_q.delete();
        pbm_q.delete();
        frame_idx = 0;
        done = 1;
      end
    end
  endtask

  task automatic run_frame(input logic [15:0] len, input int nbuf, input logic [31:0] base, input bit legal);
    load_pbm(nbuf, base);
    if (legal) push_frame(len, nbuf, base, 1'b0);
    send_meta(len);
    wait_idle();
  endtask

  // PBM model: pops on a handshake seen mid-cycle, presents the next word.
  initial begin
    bit pop;
    forever begin
      @(negedge clk);
      pop = rst_n && i_pbm_rvalid && o_pbm_rready;
      @(posedge clk); #1;
      if (pop && pbm_q.size() > 0) void'(pbm_q.pop_front());
      if (pbm_q.size() > 0) begin
        {i_pbm_rlast, i_pbm_rdata} = pbm_q[0];
        i_pbm_rvalid = 1'b1;
      end else begin
        {i_pbm_rlast, i_pbm_rdata} = '0;
        i_pbm_rvalid = 1'b0;
      end
    end
  end

  // MAC backpressure: toggling, with one 5-cycle stall while w6 is shown.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        if (frame_idx == 6 && stall_cnt < 5) begin
          m_axis_tready = 1'b0;
          stall_cnt++;
        end else begin
          m_axis_tready = ~m_axis_tready;
        end
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  // Monitor: every presented word must match the scoreboard head, stalled
  // or not; a handshake retires it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_axis_tvalid) begin
        if (frame_idx < 11) check("hdr_no_pbm_pop", 64'(o_pbm_rready), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_word", {30'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 64'h0);
          if (m_axis_tready) frame_idx = 0;
        end else begin
          check($sformatf("word%0d", frame_idx),
                {30'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser}, {30'd0, exp_q[0]});
          if (m_axis_tready) begin
            frame_idx = exp_q[0][1] ? 0 : frame_idx + 1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_meta_ready", 64'(o_meta_ready), 64'd1);
    check("rst_tvalid", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, o_pbm_rready}, 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_counters", {tx_pkt_cnt, tx_err_cnt | tx_reject_cnt}, 64'd0);
    rst_n = 1'b1;

    // Basic frame with hand-computed header.
    load_pbm(16, 32'hA0000000);
    push_frame(16'd64, 16, 32'hA0000000, 1'b1);
    send_meta(16'd64);
    wait_idle();
    check("basic_pkt_cnt", 64'(tx_pkt_cnt), 64'd1);

    // Same frame under backpressure (ip_id now 1).
    bp_mode = 1'b1;
    stall_cnt = 0;
    run_frame(16'd64, 16, 32'hB0000000, 1'b1);
    bp_mode = 1'b0;
    check("bp_pkt_cnt", 64'(tx_pkt_cnt), 64'd2);

    // Rejected requests: misaligned, zero, too long.
    run_frame(16'd20, 4, 32'hC0000000, 1'b0);
    run_frame(16'd0, 4, 32'hC1000000, 1'b0);
    run_frame(16'd1488, 4, 32'hC2000000, 1'b0);
    check("reject_cnt", 64'(tx_reject_cnt), 64'd3);
    check("reject_no_pkt", 64'(tx_pkt_cnt), 64'd2);

    // Short buffer, then a normal frame.
    run_frame(16'd32, 5, 32'hD0000000, 1'b1);
    check("short_err_cnt", 64'(tx_err_cnt), 64'd1);
    run_frame(16'd16, 4, 32'hD1000000, 1'b1);
    check("after_short_pkt", 64'(tx_pkt_cnt), 64'd3);

    // Long buffer: two trailing words dropped.
    run_frame(16'd16, 6, 32'hE0000000, 1'b1);
    check("long_err_cnt", 64'(tx_err_cnt), 64'd2);

    // ip_id wrap.
    @(negedge clk);
    force dut.ip_id = 16'hFFFF;
    @(posedge clk); #1;
    release dut.ip_id;
    exp_ip_id = 16'hFFFF;
    run_frame(16'd16, 4, 32'hF0000000, 1'b1);
    run_frame(16'd16, 4, 32'hF1000000, 1'b1);
    check("wrap_pkt_cnt", 64'(tx_pkt_cnt), 64'd5);

    // Reset while header word 3 is on the bus.
    begin
      int n = 0;
      load_pbm(4, 32'h90000000);
      push_frame(16'd16, 4, 32'h90000000, 1'b0);
      send_meta(16'd16);
      while (frame_idx != 3 && n < 200) begin
        @(negedge clk); #1;
        n++;
      end
      check("reach_w3", 64'(frame_idx), 64'd3);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #3;
      check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("midrst_cnts", {tx_pkt_cnt, tx_err_cnt | tx_reject_cnt}, 64'd0);
      check("midrst_meta_ready", 64'(o_meta_ready), 64'd1);
      exp_q.delete();
      pbm_q.delete();
      frame_idx = 0;
      exp_ip_id = 16'h0000;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end

    // ip_id back to zero after reset.
    run_frame(16'd16, 4, 32'h91000000, 1'b1);
    check("post_rst_pkt", 64'(tx_pkt_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
